// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider: unsigned quotient/remainder of operand
// magnitudes over 32 cycles, with sign and divide-by-zero flags for the correction stage.
module div_iter_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [1:0]  op_div_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        dividend_neg_o,
  output logic        divisor_neg_o,
  output logic        div_zero_o,
  output logic [1:0]  op_div_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_dnd_neg;
  logic        r_dvs_neg;
  logic        r_div_zero;

  logic        w_accept;
  logic        w_dnd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dnd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_shift_rem;
  logic [32:0] w_trial;

  assign w_accept  = (r_state == S_IDLE) & start_i & ~kill_i;
  assign w_dnd_neg = op_div_i[1] & dividend_i[31];
  assign w_dvs_neg = op_div_i[1] & divisor_i[31];
  assign w_dnd_mag = w_dnd_neg ? (~dividend_i + 32'd1) : dividend_i;
  assign w_dvs_mag = w_dvs_neg ? (~divisor_i + 32'd1) : divisor_i;

  // Shifted remainder keeps the bit that leaves r_rem[31]; when that bit is set the
  // trial is always non-negative and below 2^32, so bit 32 remains a valid borrow flag.
  assign w_shift_rem = {r_rem, r_quo[31]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvsr};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = (divisor_i == 32'd0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == 5'd0) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_quo      <= 32'd0;
      r_rem      <= 32'd0;
      r_dvsr     <= 32'd0;
      r_cnt      <= 5'd0;
      r_op       <= 2'd0;
      r_dnd_neg  <= 1'b0;
      r_dvs_neg  <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op_div_i;
      r_dnd_neg <= w_dnd_neg;
      r_dvs_neg <= w_dvs_neg;
      r_dvsr    <= w_dvs_mag;
      r_cnt     <= 5'd31;
      if (divisor_i == 32'd0) begin
        r_quo      <= 32'hFFFF_FFFF;
        r_rem      <= dividend_i;
        r_div_zero <= 1'b1;
      end else begin
        r_quo      <= w_dnd_mag;
        r_rem      <= 32'd0;
        r_div_zero <= 1'b0;
      end
    end else if ((r_state == S_CALC) && !kill_i) begin
      r_cnt <= r_cnt - 5'd1;
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift_rem[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = (r_state == S_DONE);
  assign quotient_o     = r_quo;
  assign remainder_o    = r_rem;
  assign dividend_neg_o = r_dnd_neg;
  assign divisor_neg_o  = r_dvs_neg;
  assign div_zero_o     = r_div_zero;
  assign op_div_o       = r_op;

endmodule

// File: tb/tb_div_iter_unit.sv
// Randomized and directed bench for div_iter_unit against an arithmetic reference model.
module tb_div_iter_unit;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, kill_i;
  logic [1:0]  op_div_i;
  logic [31:0] dividend_i, divisor_i;
  logic        busy_o, done_o, dividend_neg_o, divisor_neg_o, div_zero_o;
  logic [31:0] quotient_o, remainder_o;
  logic [1:0]  op_div_o;

  div_iter_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .kill_i(kill_i),
    .op_div_i(op_div_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o), .remainder_o(remainder_o),
    .dividend_neg_o(dividend_neg_o), .divisor_neg_o(divisor_neg_o),
    .div_zero_o(div_zero_o), .op_div_o(op_div_o)
  );

  always #5 clk_i = ~clk_i;

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  int n_vec = 0;
  int n_err = 0;
  int e0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dn, output logic vn, output logic dz);
    logic [31:0] ma, mb;
    dn = op[1] & a[31];
    vn = op[1] & b[31];
    ma = dn ? -a : a;
    mb = vn ? -b : b;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_div_i = op; dividend_i = a; divisor_i = b;
    @(negedge clk_i);
    e0 = edge_cnt - 1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        lat = edge_cnt - e0;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic dn, vn, dz;
    int lat;
    ref_div(op, a, b, q, r, dn, vn, dz);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), dz ? 64'd1 : 64'd33);
    chk({tag, "_quo"}, 64'(quotient_o), 64'(q));
    chk({tag, "_rem"}, 64'(remainder_o), 64'(r));
    chk({tag, "_flags"}, 64'({dividend_neg_o, divisor_neg_o, div_zero_o, op_div_o}),
        64'({dn, vn, dz, op}));
    @(negedge clk_i);
    chk({tag, "_after"}, 64'({busy_o, done_o}), 64'd0);
  endtask

  task automatic do_div(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    start_op(op, a, b);
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    check_result(tag, op, a, b);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic abort_run(input string tag, input bit use_reset);
    int n_done;
    start_op(2'b00, 32'd100, 32'd7);
    repeat (9) @(negedge clk_i);
    if (use_reset) reset_i = 1'b1; else kill_i = 1'b1;
    @(negedge clk_i);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    if (use_reset) begin
      chk({tag, "_zq"}, 64'({quotient_o, remainder_o}), 64'd0);
      chk({tag, "_zf"}, 64'({done_o, dividend_neg_o, divisor_neg_o, div_zero_o, op_div_o}), 64'd0);
    end
    reset_i = 1'b0; kill_i = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) n_done++;
    end
    chk({tag, "_nodone"}, 64'(n_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    op_div_i = 2'b00; dividend_i = 32'd0; divisor_i = 32'd0;
    repeat (2) @(negedge clk_i);
    chk("rst_quo", 64'(quotient_o), 64'd0);
    chk("rst_rem", 64'(remainder_o), 64'd0);
    chk("rst_ctl", 64'({busy_o, done_o, dividend_neg_o, divisor_neg_o, div_zero_o, op_div_o}), 64'd0);
    reset_i = 1'b0;

    do_div("u100_7", 2'b00, 32'd100, 32'd7);
    chk("u100_7_q14", 64'(quotient_o), 64'd14);
    do_div("s_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("s_m7_2_q3r1", 64'({quotient_o, remainder_o}), {32'd3, 32'd1});
    do_div("s_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("s_min_m1_q", 64'(quotient_o), 64'h8000_0000);
    do_div("u_max_1", 2'b00, 32'hFFFF_FFFF, 32'd1);
    do_div("u_max_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_div("dz", 2'b00, 32'h1234_5678, 32'd0);
    chk("dz_val", 64'({quotient_o, remainder_o}), {32'hFFFF_FFFF, 32'h1234_5678});

    start_op(2'b00, 32'd100, 32'd7);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    check_result("ign_start", 2'b00, 32'd100, 32'd7);
    do_div("u9_3", 2'b00, 32'd9, 32'd3);
    chk("u9_3_q3r0", 64'({quotient_o, remainder_o}), {32'd3, 32'd0});

    abort_run("kill", 1'b0);
    abort_run("reset", 1'b1);
    do_div("post_rst", 2'b00, 32'd100, 32'd7);
    chk("post_rst_val", 64'({quotient_o, remainder_o}), {32'd14, 32'd2});

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      do_div($sformatf("rnd%0d", i), op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative radix-2 restoring divider core for the M-extension datapath. Accepts a 32-bit dividend/divisor pair with the DIV/DIVU/REM/REMU selector and converts signed operands to magnitudes. Computes the unsigned quotient and remainder of those magnitudes over 32 cycles. Results, operand sign flags and a divide-by-zero flag go directly to the downstream division output-correction stage, which applies the final sign fix-up and selects quotient or remainder.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- clk_i  input  1  core clock; all state changes on rising edge
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  request a division; accepted only in IDLE
- kill_i  input  1  synchronous abort (pipeline flush); returns to IDLE, no done_o
- op_div_i  input  2  bit1 = signed, bit0 = remainder requested; sampled with start_i
- dividend_i  input  32  dividend; sampled with start_i
- divisor_i  input  32  divisor; sampled with start_i
- busy_o  output  1  high in CALC and DONE
- done_o  output  1  single-cycle result-valid pulse
- quotient_o  output  32  unsigned quotient of magnitudes
- remainder_o  output  32  unsigned remainder of magnitudes
- dividend_neg_o  output  1  op_div[1] & dividend[31]
- divisor_neg_o  output  1  op_div[1] & divisor[31]
- div_zero_o  output  1  divisor was zero
- op_div_o  output  2  latched op_div_i, for the correction stage

## Operation
- States: IDLE, CALC, DONE. Reset and kill_i force IDLE.
- IDLE + start_i:
  - Latch op_div_i.
  - Form magnitudes: if op_div_i[1] and bit31 set, magnitude = (~x + 1) mod 2^32, otherwise x. 0x80000000 keeps magnitude 0x80000000 as an unsigned value.
  - Latch the sign flags and clear div_zero_o.
- divisor_i == 0 at accept: go straight to DONE.
  - quotient_o = 0xFFFFFFFF, remainder_o = raw dividend_i, div_zero_o = 1.
  - Sign flags latched as normal.
- Otherwise go to CALC.
  - Load the quotient register with |dividend| and the partial remainder with 0.
  - Load the 5-bit iteration counter with 31.
- CALC iteration, one per cycle:
  - Shift {rem, quo} left 1 and form 33-bit trial = shifted_rem − |divisor|.
  - If trial[32] = 0: rem = trial[31:0] and quo[0] = 1.
  - Else: rem = shifted_rem and quo[0] = 0.
  - Counter decrements. The iteration with counter = 0 moves the FSM to DONE.
- DONE:
  - done_o = 1 for exactly this cycle.
  - Next state IDLE unconditionally; start_i in DONE is ignored.
- quotient_o, remainder_o, the flags and op_div_o hold their last values from DONE until the next accepted start_i.
- start_i in CALC/DONE is ignored; no queuing.
- kill_i has priority over start_i and over the CALC/DONE transitions.
  - done_o is not asserted in the kill cycle or afterwards.
  - Result registers may hold partial values after a kill.

## Timing
- Reset values: busy_o = 0, done_o = 0, all data outputs and flags = 0, state IDLE.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs zeroed; no done_o after release.
- Normal latency: start_i sampled at edge E0, iterations at E1..E32.
  - done_o is high in the cycle after E32 and is sampled by the consumer at E33.
  - busy_o is high from after E0 until E33.
- Divide-by-zero latency: start_i at E0, done_o sampled at E1.
- Back-to-back: earliest next accept is the edge at which done_o is sampled + 1, i.e. the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7 (op_div=00): done_o sampled 33 edges after start; quotient_o = 14, remainder_o = 2, both sign flags 0, div_zero_o = 0.
- Signed −7 / 2 (op_div=10, dividend 0xFFFFFFF9): quotient_o = 3, remainder_o = 1, dividend_neg_o = 1, divisor_neg_o = 0, op_div_o = 10.
- Signed 0x80000000 / 0xFFFFFFFF (op_div=11): quotient_o = 0x80000000, remainder_o = 0, both neg flags 1; unsigned 0xFFFFFFFF / 1 gives quotient_o = 0xFFFFFFFF, remainder_o = 0.
- Divisor 0, dividend 0x12345678: done_o sampled 1 edge after start; quotient_o = 0xFFFFFFFF, remainder_o = 0x12345678, div_zero_o = 1.
- start_i pulsed again at E5 of a 100 / 7 run with operands 9 / 3: ignored; result is still 14 / 2 at E33; 9 / 3 accepted only when re-issued in IDLE, giving 3 / 0.
- kill_i at E10, and separately reset_i at E10: no done_o within 40 cycles; busy_o = 0 the following cycle. Reset also zeroes all outputs; a fresh 100 / 7 afterwards returns 14 / 2.
